// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: sequencer for a carry-save multi-operand accumulator.
// Operands are folded into redundant sum/carry registers at one per cycle.
// The last operand starts a CHUNK-bit carry-propagate pass that resolves
// sum+carry into a binary result, LSB chunk first.
module csa_accum_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CHUNK      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [15:0]           out_count,
    output logic                  busy
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] sum_r;
    logic [DATA_WIDTH-1:0] carry_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [15:0]           count;
    logic                  cy_r;
    logic [IDX_W-1:0]      chunk_idx;

    logic [DATA_WIDTH-1:0] csa_sum;
    logic [DATA_WIDTH-1:0] csa_maj;
    logic [DATA_WIDTH-1:0] csa_carry;
    logic [CHUNK:0]        chunk_sum;
    logic [15:0]           count_inc;
    logic                  accept;

    assign accept = in_valid & in_ready;

    // 3:2 compression of the redundant pair with the incoming operand; the
    // shifted-out MSB carry is dropped so the sum wraps mod 2^DATA_WIDTH.
    assign csa_sum   = sum_r ^ carry_r ^ in_data;
    assign csa_maj   = (sum_r & carry_r) | (sum_r & in_data) | (carry_r & in_data);
    assign csa_carry = csa_maj << 1;

    // One slice of the carry-propagate adder, selected by the current chunk index.
    assign chunk_sum = {1'b0, sum_r[chunk_idx*CHUNK +: CHUNK]}
                     + {1'b0, carry_r[chunk_idx*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, cy_r};

    // Operand count saturates instead of wrapping on very long sums.
    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = out_data_r;
    assign out_count = count;

    // State machine plus datapath registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sum_r      <= '0;
            carry_r    <= '0;
            out_data_r <= '0;
            count      <= '0;
            cy_r       <= 1'b0;
            chunk_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum_r     <= in_data;
                        carry_r   <= '0;
                        count     <= 16'd1;
                        cy_r      <= 1'b0;
                        chunk_idx <= '0;
                        state     <= in_last ? RESOLVE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sum_r   <= csa_sum;
                        carry_r <= csa_carry;
                        count   <= count_inc;
                        if (in_last) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_data_r[chunk_idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    if (chunk_idx == LAST_IDX) begin
                        cy_r      <= 1'b0;
                        chunk_idx <= '0;
                        state     <= DONE;
                    end else begin
                        cy_r      <= chunk_sum[CHUNK];
                        chunk_idx <= chunk_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: directed and randomized checks of csa_accum_ctrl.
// Three instances cover CHUNK = 8, 1 and 32; the expected result of every
// sum is the plain 32-bit arithmetic total of the operands fed in.
module tb_csa_accum_ctrl;

    localparam int NU = 3;
    localparam int CHUNKS [NU] = '{8, 1, 32};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [NU];
    logic        in_ready  [NU];
    logic [31:0] in_data   [NU];
    logic        in_last   [NU];
    logic        out_valid [NU];
    logic        out_ready [NU];
    logic [31:0] out_data  [NU];
    logic [15:0] out_count [NU];
    logic        busy      [NU];

    int errors = 0;
    int checks = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        csa_accum_ctrl #(.DATA_WIDTH(32), .CHUNK(CHUNKS[g])) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_last   (in_last[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_count (out_count[g]),
            .busy      (busy[g])
        );
    end

    function automatic int numChunks(int u);
        return 32 / CHUNKS[u];
    endfunction

    // Single comparison point: counts every check and reports any mismatch.
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand starting at a falling edge and returns at the
    // falling edge right after the clock edge that accepted it.
    task automatic applyStimulus(int u, logic [31:0] d, logic last);
        int waited = 0;
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_last[u]  = last;
        while (!in_ready[u] && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            chk($sformatf("u%0d accept_timeout", u), 32'd1, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_data[u]  = $urandom;
        in_last[u]  = 1'b1;
    endtask

    // Waits for the result, checks latency, value and count, optionally
    // stalls the consumer, then releases it and checks the return to idle.
    task automatic checkOutput(int u, logic [31:0] exp_d, logic [15:0] exp_c, int hold);
        int cycles = 0;
        while (!out_valid[u] && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        chk($sformatf("u%0d latency", u), cycles, numChunks(u));
        chk($sformatf("u%0d out_data", u), out_data[u], exp_d);
        chk($sformatf("u%0d out_count", u), 32'(out_count[u]), 32'(exp_c));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("u%0d hold_valid", u), 32'(out_valid[u]), 32'd1);
            chk($sformatf("u%0d hold_data", u), out_data[u], exp_d);
            chk($sformatf("u%0d hold_count", u), 32'(out_count[u]), 32'(exp_c));
            chk($sformatf("u%0d hold_in_ready", u), 32'(in_ready[u]), 32'd0);
        end
        out_ready[u] = 1'b1;
        chk($sformatf("u%0d release_in_ready", u), 32'(in_ready[u]), 32'd0);
        @(negedge clk);
        out_ready[u] = 1'b0;
        chk($sformatf("u%0d idle_busy", u), 32'(busy[u]), 32'd0);
        chk($sformatf("u%0d idle_in_ready", u), 32'(in_ready[u]), 32'd1);
        chk($sformatf("u%0d idle_out_valid", u), 32'(out_valid[u]), 32'd0);
    endtask

    // Directed scenarios on the default instance, then randomized sums on all.
    initial begin
        logic [31:0] acc;
        logic [15:0] cnt;
        logic [31:0] d;
        logic        last;

        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = '0;
            in_last[u]   = 1'b0;
            out_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("u%0d rst_out_data", u), out_data[u], 32'd0);
            chk($sformatf("u%0d rst_out_count", u), 32'(out_count[u]), 32'd0);
            chk($sformatf("u%0d rst_in_ready", u), 32'(in_ready[u]), 32'd1);
            chk($sformatf("u%0d rst_out_valid", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("u%0d rst_busy", u), 32'(busy[u]), 32'd0);
        end

        $display("[TB] back-to-back 1+2+3");
        applyStimulus(0, 32'd1, 1'b0);
        applyStimulus(0, 32'd2, 1'b0);
        applyStimulus(0, 32'd3, 1'b1);
        checkOutput(0, 32'd6, 16'd3, 0);

        $display("[TB] single all-ones operand");
        applyStimulus(0, 32'hFFFF_FFFF, 1'b1);
        checkOutput(0, 32'hFFFF_FFFF, 16'd1, 0);

        $display("[TB] wraparound sums");
        applyStimulus(0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(0, 32'h0000_0001, 1'b1);
        checkOutput(0, 32'h0000_0000, 16'd2, 0);
        applyStimulus(0, 32'h8000_0000, 1'b0);
        applyStimulus(0, 32'h8000_0000, 1'b0);
        applyStimulus(0, 32'h8000_0000, 1'b1);
        checkOutput(0, 32'h8000_0000, 16'd3, 0);

        $display("[TB] consumer stall in DONE");
        applyStimulus(0, 32'h1234_5678, 1'b0);
        applyStimulus(0, 32'h1111_1111, 1'b1);
        checkOutput(0, 32'h2345_6789, 16'd2, 6);

        $display("[TB] reset during resolve");
        applyStimulus(0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(0, 32'h0BAD_F00D, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
        chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort_out_data", out_data[0], 32'd0);
        chk("abort_out_count", 32'(out_count[0]), 32'd0);
        applyStimulus(0, 32'd5, 1'b0);
        applyStimulus(0, 32'd7, 1'b1);
        checkOutput(0, 32'd12, 16'd2, 0);

        $display("[TB] randomized sums with gaps");
        for (int u = 0; u < NU; u++) begin
            acc = '0;
            cnt = '0;
            for (int i = 0; i < 100; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data[u] = $urandom;
                    in_last[u] = 1'b1;
                    @(negedge clk);
                end
                d    = $urandom;
                last = (i == 99) || ($urandom_range(0, 7) == 0);
                acc  = acc + d;
                cnt  = cnt + 16'd1;
                applyStimulus(u, d, last);
                if (last) begin
                    checkOutput(u, acc, cnt, $urandom_range(0, 2));
                    acc = '0;
                    cnt = '0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
